// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core (port 0)
// and a secondary master (port 1); one access cycle per grant, registered ack/err/rdata.
module data_memory_arbiter #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 256,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h10010000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [DATA_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_ack,
  output logic                  p0_err,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [DATA_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_ack,
  output logic                  p1_err,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_last_grant;
  logic                  r_port;
  logic                  r_we;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_p0_ack;
  logic                  r_p1_ack;
  logic                  r_p0_err;
  logic                  r_p1_err;
  logic [DATA_WIDTH-1:0] r_p0_rdata;
  logic [DATA_WIDTH-1:0] r_p1_rdata;

  logic                  w_grant_valid;
  logic                  w_grant_port;
  logic                  w_sel_we;
  logic [DATA_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic                  w_sel_in_win;
  logic                  w_access;

  // Offset arithmetic wraps, so addresses below the base land far above the window.
  function automatic logic in_window(input logic [DATA_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return off < DATA_WIDTH'(MEMORY_DEPTH);
  endfunction

  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_port  = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant_valid = p0_req | p1_req;
        w_grant_port  = (p0_req & p1_req) ? ~r_last_grant : p1_req;
      end
      // The finishing port still holds req here; only the other port may be granted.
      ACK: begin
        w_grant_valid = r_port ? p0_req : p1_req;
        w_grant_port  = ~r_port;
      end
      default: begin
        w_grant_valid = 1'b0;
        w_grant_port  = 1'b0;
      end
    endcase
  end

  assign w_sel_we     = w_grant_port ? p1_we    : p0_we;
  assign w_sel_addr   = w_grant_port ? p1_addr  : p0_addr;
  assign w_sel_wdata  = w_grant_port ? p1_wdata : p0_wdata;
  assign w_sel_in_win = in_window(w_sel_addr);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    w_next_state = w_grant_valid ? ACCESS : IDLE;
      ACCESS:  w_next_state = ACK;
      ACK:     w_next_state = w_grant_valid ? ACCESS : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Winner latch; the memory-facing address/data only move for in-window accesses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_we         <= 1'b0;
      r_err        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else if (w_grant_valid) begin
      r_last_grant <= w_grant_port;
      r_port       <= w_grant_port;
      r_we         <= w_sel_we;
      r_err        <= ~w_sel_in_win;
      r_addr       <= w_sel_addr;
      r_wdata      <= w_sel_wdata;
      if (w_sel_in_win) begin
        r_mem_addr  <= w_sel_addr;
        r_mem_wdata <= w_sel_wdata;
      end
    end
  end

  assign w_access = (r_state == ACCESS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p0_ack   <= 1'b0;
      r_p1_ack   <= 1'b0;
      r_p0_err   <= 1'b0;
      r_p1_err   <= 1'b0;
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
    end else begin
      r_p0_ack <= w_access & ~r_port;
      r_p1_ack <= w_access &  r_port;
      r_p0_err <= w_access & ~r_port & r_err;
      r_p1_err <= w_access &  r_port & r_err;
      if (w_access & ~r_port) begin
        if (r_err)      r_p0_rdata <= '0;
        else if (!r_we) r_p0_rdata <= mem_rdata;
      end
      if (w_access & r_port) begin
        if (r_err)      r_p1_rdata <= '0;
        else if (!r_we) r_p1_rdata <= mem_rdata;
      end
    end
  end

  // Strobes decode straight from state so an asynchronous reset cancels them at once.
  assign mem_write = w_access & ~r_err &  r_we;
  assign mem_read  = w_access & ~r_err & ~r_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign p0_ack    = r_p0_ack;
  assign p1_ack    = r_p1_ack;
  assign p0_err    = r_p0_err;
  assign p1_err    = r_p1_err;
  assign p0_rdata  = r_p0_rdata;
  assign p1_rdata  = r_p1_rdata;

endmodule
